jtag_dtm_host: RTL and testbench
================================

Name: jtag_dtm_host

Overview:
Synthesizable JTAG host (initiator) for the debug transport path. It drives TCK/TMS/TDI into the DTM TAP and samples TDO. Commands arrive on a valid/ready interface and are expanded into TAP reset, IR-scan, DR-scan or idle-clock sequences. Each command returns captured TDO bits on a valid/ready response channel. Used by the debug-module testbench and by on-chip self-test to reach DTMCS and DMI without an external probe.

Parameters:
ClkDiv, 2, clk_i cycles per TCK half-period (>=1)
MaxLen, 64, maximum scan length in bits (>=41, the DMI width)
TdoRegistered, 1, 1 = target launches TDO on TCK rising edge, so the capture window shifts one TCK later
LenW, $clog2(MaxLen)+1, width of the length field (derived)

Ports:
clk_i  in  1  system clock
trst_ni  in  1  reset, asynchronous, active-low
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command accepted when valid&ready
cmd_op_i  in  2  00 TAP_RESET, 01 IR_SCAN, 10 DR_SCAN, 11 RUN_IDLE
cmd_len_i  in  LenW  scan bits or idle TCKs; 0 treated as 1; values >MaxLen clamp to MaxLen
cmd_data_i  in  MaxLen  TDI bits, bit0 shifted first
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response accepted
rsp_data_o  out  MaxLen  captured TDO, bit i = i-th captured bit, bits >= len zero
tck_o  out  1  TCK
tms_o  out  1  TMS
tdi_o  out  1  TDI
tdo_i  in  1  TDO from target

Behaviour:
- Reset values: tck_o=0, tms_o=1, tdi_o=0, cmd_ready_o=0, rsp_valid_o=0, rsp_data_o=0. Reset mid-command aborts the command immediately and produces no response.
- After trst_ni deasserts, the block runs an autonomous TAP_RESET with no response. cmd_ready_o rises only after that reset finishes.
- TCK generation: a divider counts ClkDiv clk_i cycles per phase. The last low-phase cycle is the rise strobe; tck_o rises on the next cycle. The last high-phase cycle is the fall strobe.
- tms_o and tdi_o are registered. They change only in the cycle tck_o falls, or at command acceptance while tck_o=0. They are never changed across a rising edge.
- tdo_i is sampled on the rise strobe, i.e. immediately before TCK rises.
- Idle: tck_o parked low, tms_o=0 (TAP held in RunTestIdle). cmd_ready_o=1 only when idle and rsp_valid_o=0.
- The first TCK rising edge occurs ClkDiv cycles after acceptance.
- TMS sequences (one value per rising edge, N = effective length):
  - TAP_RESET: 1,1,1,1,1,0. 6 edges.
  - DR_SCAN: 1,0,0, then N shift edges (0 for N-1 edges, 1 on the last), then 1,0. N+5 edges.
  - IR_SCAN: 1,1,0,0, then the same shift pattern, then 1,0. N+6 edges.
  - RUN_IDLE: N edges of 0.
- TDI: bit k of cmd_data is presented for the k-th shift edge. tdi_o=0 outside shift edges.
- Capture window:
  - TdoRegistered=0: sample before each of the N shift edges.
  - TdoRegistered=1: sample before shift edges 2..N, plus the Exit1->Update edge.
  - Either way exactly N bits are captured, filled LSB-first.
- Response: rsp_valid_o asserts the cycle after the final falling edge of the sequence. It is held with stable data until rsp_ready_i. TAP_RESET and RUN_IDLE respond with data 0. An accepted command always yields exactly one response unless reset intervenes.
- FSM: RESET_SEQ -> IDLE -> {PRE (SelectDR/SelectIR/Capture steps), SHIFT, POST (Exit1/Update/RTI steps), IDLE_RUN} -> RESP -> IDLE.
  - A step counter indexes PRE/POST TMS bits.
  - A bit counter (LenW) counts shift and capture bits.
  - A MaxLen shift register holds TDI data; a MaxLen capture register collects TDO.
- Simultaneous cmd_valid_i and pending response: the command waits. No command is accepted in the same cycle a response is consumed; it is accepted the following cycle.

Decomposition:
- Package jtag_dtm_host_pkg:
  - jtag_op_e encodings
  - host_state_e
  - TMS pre/post sequence constants
  - IR codes IDCODE=5'h01, DTMCSR=5'h10, DMIACCESS=5'h11, BYPASS=5'h1f
- Sub-module jtag_tck_gen: divider producing tck_o plus rise/fall strobes. Parameter ClkDiv, inputs clk_i/trst_ni/run.

Test Plan:
1. Reset: hold trst_ni low 5 cycles -> tck_o=0, tms_o=1, cmd_ready_o=0. After release, exactly 6 TCK rises with TMS 1,1,1,1,1,0, then cmd_ready_o=1 and TCK parked low.
2. IR_SCAN len 5 data 0x01 against DTM TAP (TdoRegistered=1) -> TMS 1,1,0,0,0,0,0,0,1,1,0 (11 edges), rsp_data_o=0x05 (IR capture pattern 00101).
3. DR_SCAN len 32 after IR=IDCODE, TAP IdCodeValue=0xDEADBEEF -> 37 rising edges, rsp_data_o[31:0]=0xDEADBEEF, upper bits 0.
4. IR=0x1F then DR_SCAN len 8 data 0xA5 -> rsp_data_o=0x4A (one-bit bypass delay, leading 0).
5. ClkDiv=3 -> every TCK high/low phase exactly 3 clk_i cycles. TMS/TDI never change within 3 cycles before a rise. RUN_IDLE len 4 -> 4 rises with TMS=0, rsp_data_o=0.
6. Hold rsp_ready_i low 20 cycles -> rsp_valid_o/rsp_data_o stable, cmd_ready_o=0. Assert trst_ni mid DR shift -> outputs return to reset values, no response. A new 6-edge reset sequence runs after release.

Source files
------------

// File: rtl/jtag_dtm_host_pkg.sv
// jtag_dtm_host_pkg
// Shared types and constants for the JTAG host that drives the DTM TAP.
//   jtag_op_e    : command opcodes on cmd_op_i
//   host_state_e : sequencer states of jtag_dtm_host
//   Tms*         : TMS bit patterns, bit i is the TMS value for the i-th rising edge
//   Ir*          : DTM instruction register codes
package jtag_dtm_host_pkg;

  typedef enum logic [1:0] {
    OpTapReset = 2'b00,
    OpIrScan   = 2'b01,
    OpDrScan   = 2'b10,
    OpRunIdle  = 2'b11
  } jtag_op_e;

  typedef enum logic [2:0] {
    StResetSeq,
    StIdle,
    StPre,
    StShift,
    StPost,
    StIdleRun,
    StResp
  } host_state_e;

  // Five TMS=1 edges reach Test-Logic-Reset from any state, the sixth parks in RunTestIdle.
  localparam logic [5:0] TmsResetSeq  = 6'b011111;
  localparam logic [2:0] ResetSeqLast = 3'd5;

  // RunTestIdle -> SelectDR -> CaptureDR -> ShiftDR
  localparam logic [3:0] TmsPreDr  = 4'b0001;
  localparam logic [2:0] PreDrLast = 3'd2;

  // RunTestIdle -> SelectDR -> SelectIR -> CaptureIR -> ShiftIR
  localparam logic [3:0] TmsPreIr  = 4'b0011;
  localparam logic [2:0] PreIrLast = 3'd3;

  // Exit1 -> Update -> RunTestIdle
  localparam logic [1:0] TmsPost  = 2'b01;
  localparam logic [2:0] PostLast = 3'd1;

  localparam logic [4:0] IrIdcode    = 5'h01;
  localparam logic [4:0] IrDtmcs     = 5'h10;
  localparam logic [4:0] IrDmiAccess = 5'h11;
  localparam logic [4:0] IrBypass    = 5'h1f;

endpackage

// File: rtl/jtag_tck_gen.sv
// jtag_tck_gen
// TCK divider. Each TCK phase lasts ClkDiv clk_i cycles while run_i is high;
// with run_i low TCK is parked low and the divider is cleared so the first
// rise after run_i goes high comes exactly ClkDiv cycles later.
//   clk_i   : system clock
//   trst_ni : asynchronous active-low reset
//   run_i   : enable TCK toggling
//   tck_o   : generated TCK
//   rise_o  : last low-phase cycle, TCK rises on the next cycle
//   fall_o  : last high-phase cycle, TCK falls on the next cycle
module jtag_tck_gen #(
  parameter int ClkDiv = 2
) (
  input  logic clk_i,
  input  logic trst_ni,
  input  logic run_i,
  output logic tck_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CntW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(ClkDiv - 1);

  logic [CntW-1:0] cnt_q;
  logic            tck_q;
  logic            phaseEnd;

  assign phaseEnd = run_i && (cnt_q == CntLast);
  assign rise_o   = phaseEnd && !tck_q;
  assign fall_o   = phaseEnd && tck_q;
  assign tck_o    = tck_q;

  // Phase counter and TCK toggle; idle clears both so TCK restarts from a full low phase.
  always_ff @(posedge clk_i or negedge trst_ni) begin
    if (!trst_ni) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else if (!run_i) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else if (phaseEnd) begin
      cnt_q <= '0;
      tck_q <= ~tck_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/jtag_dtm_host.sv
// jtag_dtm_host
// JTAG initiator for the DTM TAP. Expands commands into TAP reset, IR scan,
// DR scan or idle clocking and returns the captured TDO bits.
//   clk_i, trst_ni          : clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o : command handshake
//   cmd_op_i                : jtag_op_e opcode
//   cmd_len_i               : scan bits / idle TCKs (0 -> 1, clamped to MaxLen)
//   cmd_data_i              : TDI bits, bit0 shifted first
//   rsp_valid_o/rsp_ready_i : response handshake
//   rsp_data_o              : captured TDO, bit i = i-th captured bit
//   tck_o, tms_o, tdi_o     : to target TAP
//   tdo_i                   : from target TAP
module jtag_dtm_host
  import jtag_dtm_host_pkg::*;
#(
  parameter int ClkDiv        = 2,
  parameter int MaxLen        = 64,
  parameter bit TdoRegistered = 1'b1,
  parameter int LenW          = $clog2(MaxLen) + 1
) (
  input  logic              clk_i,
  input  logic              trst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [1:0]        cmd_op_i,
  input  logic [LenW-1:0]   cmd_len_i,
  input  logic [MaxLen-1:0] cmd_data_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [MaxLen-1:0] rsp_data_o,
  output logic              tck_o,
  output logic              tms_o,
  output logic              tdi_o,
  input  logic              tdo_i
);

  localparam int IdxW = $clog2(MaxLen);

  host_state_e       state_q, state_d;
  jtag_op_e          op_q, op_d;
  logic [2:0]        step_q, step_d;
  logic [LenW-1:0]   bit_q, bit_d;
  logic [LenW-1:0]   len_q, len_d;
  logic [MaxLen-1:0] sr_q, sr_d;
  logic [MaxLen-1:0] cap_q, cap_d;
  logic              respond_q, respond_d;
  logic              tms_q, tms_d;
  logic              tdi_q, tdi_d;
  logic              run, rise, fall;
  logic [LenW-1:0]   lenEff;
  logic [IdxW-1:0]   capIdx;
  logic              capEn;

  jtag_tck_gen #(.ClkDiv(ClkDiv)) u_tck_gen (
    .clk_i  (clk_i),
    .trst_ni(trst_ni),
    .run_i  (run),
    .tck_o  (tck_o),
    .rise_o (rise),
    .fall_o (fall)
  );

  assign run = (state_q == StResetSeq) || (state_q == StPre) || (state_q == StShift) ||
               (state_q == StPost) || (state_q == StIdleRun);

  assign cmd_ready_o = (state_q == StIdle);
  assign rsp_valid_o = (state_q == StResp);
  assign rsp_data_o  = cap_q;
  assign tms_o       = tms_q;
  assign tdi_o       = tdi_q;

  // Zero length means one bit; anything beyond the register width is clamped.
  always_comb begin
    lenEff = cmd_len_i;
    if (cmd_len_i == '0) begin
      lenEff = LenW'(1);
    end else if (cmd_len_i > LenW'(MaxLen)) begin
      lenEff = LenW'(MaxLen);
    end
  end

  // A registered TDO shows a shift bit one edge late, so its capture slides
  // from shift edges 1..N to shift edges 2..N plus the Exit1->Update edge.
  always_comb begin
    capEn  = 1'b0;
    capIdx = IdxW'(bit_q);
    if (!TdoRegistered) begin
      capEn = (state_q == StShift);
    end else if (state_q == StShift && bit_q != '0) begin
      capEn  = 1'b1;
      capIdx = IdxW'(bit_q - LenW'(1));
    end else if (state_q == StPost && step_q == 3'd0) begin
      capEn  = 1'b1;
      capIdx = IdxW'(len_q - LenW'(1));
    end
  end

  // Sequencer: every move between TAP steps happens on the fall strobe so the
  // TMS/TDI for the next edge are launched together with the falling TCK.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    step_d    = step_q;
    bit_d     = bit_q;
    len_d     = len_q;
    sr_d      = sr_q;
    cap_d     = cap_q;
    respond_d = respond_q;

    if (rise && capEn) begin
      cap_d[capIdx] = tdo_i;
    end

    case (state_q)
      StResetSeq: begin
        if (fall) begin
          if (step_q == ResetSeqLast) begin
            step_d    = 3'd0;
            respond_d = 1'b0;
            state_d   = respond_q ? StResp : StIdle;
          end else begin
            step_d = step_q + 3'd1;
          end
        end
      end
      StIdle: begin
        if (cmd_valid_i) begin
          op_d   = jtag_op_e'(cmd_op_i);
          len_d  = lenEff;
          sr_d   = cmd_data_i;
          cap_d  = '0;
          step_d = 3'd0;
          bit_d  = '0;
          case (jtag_op_e'(cmd_op_i))
            OpTapReset: begin
              state_d   = StResetSeq;
              respond_d = 1'b1;
            end
            OpRunIdle: state_d = StIdleRun;
            default:   state_d = StPre;
          endcase
        end
      end
      StPre: begin
        if (fall) begin
          if (step_q == ((op_q == OpIrScan) ? PreIrLast : PreDrLast)) begin
            step_d  = 3'd0;
            state_d = StShift;
          end else begin
            step_d = step_q + 3'd1;
          end
        end
      end
      StShift: begin
        if (fall) begin
          sr_d = sr_q >> 1;
          if (bit_q == len_q - LenW'(1)) begin
            step_d  = 3'd0;
            state_d = StPost;
          end else begin
            bit_d = bit_q + LenW'(1);
          end
        end
      end
      StPost: begin
        if (fall) begin
          if (step_q == PostLast) begin
            state_d = StResp;
          end else begin
            step_d = step_q + 3'd1;
          end
        end
      end
      StIdleRun: begin
        if (fall) begin
          if (bit_q == len_q - LenW'(1)) begin
            state_d = StResp;
          end else begin
            bit_d = bit_q + LenW'(1);
          end
        end
      end
      StResp: begin
        if (rsp_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // TMS/TDI for the upcoming edge follow the next-state values, so they only
  // move when the sequencer moves (fall strobe or command acceptance).
  always_comb begin
    tms_d = 1'b0;
    tdi_d = 1'b0;
    case (state_d)
      StResetSeq: tms_d = TmsResetSeq[step_d];
      StPre:      tms_d = (op_d == OpIrScan) ? TmsPreIr[step_d[1:0]] : TmsPreDr[step_d[1:0]];
      StShift: begin
        tms_d = (bit_d == len_d - LenW'(1));
        tdi_d = sr_d[0];
      end
      StPost:     tms_d = TmsPost[step_d[0]];
      default:    ;
    endcase
  end

  // State registers; reset lands in the autonomous TAP reset sequence.
  always_ff @(posedge clk_i or negedge trst_ni) begin
    if (!trst_ni) begin
      state_q   <= StResetSeq;
      op_q      <= OpTapReset;
      step_q    <= 3'd0;
      bit_q     <= '0;
      len_q     <= LenW'(1);
      sr_q      <= '0;
      cap_q     <= '0;
      respond_q <= 1'b0;
      tms_q     <= 1'b1;
      tdi_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      step_q    <= step_d;
      bit_q     <= bit_d;
      len_q     <= len_d;
      sr_q      <= sr_d;
      cap_q     <= cap_d;
      respond_q <= respond_d;
      tms_q     <= tms_d;
      tdi_q     <= tdi_d;
    end
  end

endmodule

// File: tb/tb_jtag_dtm_host.sv
// tb_jtag_dtm_host
// Directed bench for jtag_dtm_host with a behavioural DTM TAP model
// (registered TDO, IDCODE 0xDEADBEEF, 1-bit BYPASS) on the JTAG pins.
module tb_jtag_dtm_host;
  import jtag_dtm_host_pkg::*;

  localparam int ClkDivTb = 3;
  localparam int MaxLenTb = 64;
  localparam int LenWTb   = 7;
  localparam logic [31:0] IdCodeValue = 32'hDEADBEEF;

  logic                clk = 1'b0;
  logic                trstN = 1'b0;
  logic                cmdValid = 1'b0;
  logic                cmdReady;
  logic [1:0]          cmdOp = 2'b00;
  logic [LenWTb-1:0]   cmdLen = '0;
  logic [MaxLenTb-1:0] cmdData = '0;
  logic                rspValid;
  logic                rspReady = 1'b1;
  logic [MaxLenTb-1:0] rspData;
  logic                tck, tms, tdi, tdo;

  int errorCount = 0;
  int checkCount = 0;

  jtag_dtm_host #(
    .ClkDiv       (ClkDivTb),
    .MaxLen       (MaxLenTb),
    .TdoRegistered(1'b1)
  ) dut (
    .clk_i      (clk),
    .trst_ni    (trstN),
    .cmd_valid_i(cmdValid),
    .cmd_ready_o(cmdReady),
    .cmd_op_i   (cmdOp),
    .cmd_len_i  (cmdLen),
    .cmd_data_i (cmdData),
    .rsp_valid_o(rspValid),
    .rsp_ready_i(rspReady),
    .rsp_data_o (rspData),
    .tck_o      (tck),
    .tms_o      (tms),
    .tdi_o      (tdi),
    .tdo_i      (tdo)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      errorCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Target TAP model: standard 16-state controller, TDO launched on the rising edge.
  typedef enum logic [3:0] {
    TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PSDR, EX2DR, UPDR,
    SELIR, CAPIR, SHIR, EX1IR, PSIR, EX2IR, UPIR
  } tap_e;

  tap_e        tapState = TLR;
  logic [4:0]  tapIr = IrIdcode;
  logic [4:0]  tapIrSr = '0;
  logic [31:0] tapDrSr = '0;
  logic        tdoQ = 1'b0;

  assign tdo = tdoQ;

  function automatic tap_e tapNext(input tap_e s, input logic m);
    case (s)
      TLR:     return m ? TLR   : RTI;
      RTI:     return m ? SELDR : RTI;
      SELDR:   return m ? SELIR : CAPDR;
      CAPDR:   return m ? EX1DR : SHDR;
      SHDR:    return m ? EX1DR : SHDR;
      EX1DR:   return m ? UPDR  : PSDR;
      PSDR:    return m ? EX2DR : PSDR;
      EX2DR:   return m ? UPDR  : SHDR;
      UPDR:    return m ? SELDR : RTI;
      SELIR:   return m ? TLR   : CAPIR;
      CAPIR:   return m ? EX1IR : SHIR;
      SHIR:    return m ? EX1IR : SHIR;
      EX1IR:   return m ? UPIR  : PSIR;
      PSIR:    return m ? EX2IR : PSIR;
      EX2IR:   return m ? UPIR  : SHIR;
      default: return m ? SELDR : RTI;
    endcase
  endfunction

  always @(posedge tck) begin
    case (tapState)
      TLR:   tapIr <= IrIdcode;
      CAPIR: tapIrSr <= 5'b00101;
      SHIR: begin
        tdoQ    <= tapIrSr[0];
        tapIrSr <= {tdi, tapIrSr[4:1]};
      end
      UPIR:  tapIr <= tapIrSr;
      CAPDR: tapDrSr <= (tapIr == IrIdcode) ? IdCodeValue : 32'h0;
      SHDR: begin
        tdoQ <= tapDrSr[0];
        if (tapIr == IrIdcode) tapDrSr <= {tdi, tapDrSr[31:1]};
        else tapDrSr[0] <= tdi;
      end
      default: ;
    endcase
    tapState <= tapNext(tapState, tms);
  end

  // Pin monitor: logs TMS/TDI per rising edge and checks phase widths and setup.
  logic tmsHist [0:1023];
  logic tdiHist [0:1023];
  int   totalEdges = 0;
  int   rspSeen = 0;
  int   lowLen = 0;
  int   highLen = 0;
  int   sinceChange = 0;
  logic skipLow = 1'b1;
  logic prevTck = 1'b0;
  logic prevTms = 1'b1;
  logic prevTdi = 1'b0;

  always @(negedge clk) begin
    if (rspValid) rspSeen++;
    if (tms !== prevTms || tdi !== prevTdi) sinceChange = 0;
    else sinceChange++;
    if (tck && !prevTck) begin
      checkOutput("setupBeforeRise", 128'(sinceChange >= ClkDivTb), 128'd1);
      if (!skipLow) checkOutput("lowPhase", 128'(lowLen), 128'(ClkDivTb));
      skipLow = 1'b0;
      tmsHist[totalEdges % 1024] = tms;
      tdiHist[totalEdges % 1024] = tdi;
      totalEdges++;
      highLen = 1;
    end else if (tck) begin
      highLen++;
    end else if (prevTck) begin
      if (trstN) checkOutput("highPhase", 128'(highLen), 128'(ClkDivTb));
      lowLen = 1;
    end else begin
      lowLen++;
    end
    if (cmdValid && cmdReady) lowLen = 0;
    if (!trstN) skipLow = 1'b1;
    prevTck = tck;
    prevTms = tms;
    prevTdi = tdi;
  end

  int           base = 0;
  int           edges = 0;
  int           rspBefore = 0;
  logic [127:0] tmsSeq, tdiSeq;
  logic [63:0]  lastRsp;

  task automatic collectEdges();
    edges = totalEdges - base;
    for (int i = 0; i < 128; i++) begin
      tmsSeq[i] = (i < edges) ? tmsHist[(base + i) % 1024] : 1'b0;
      tdiSeq[i] = (i < edges) ? tdiHist[(base + i) % 1024] : 1'b0;
    end
  endtask

  // Presents a command at a negedge and holds it until accepted.
  task automatic applyStimulus(input logic [1:0] op, input logic [LenWTb-1:0] len,
                               input logic [MaxLenTb-1:0] data);
    cmdValid = 1'b1;
    cmdOp    = op;
    cmdLen   = len;
    cmdData  = data;
    for (int i = 0; i < 400 && !cmdReady; i++) @(negedge clk);
    checkOutput("acceptReady", 128'(cmdReady), 128'd1);
    base = totalEdges;
    @(negedge clk);
    cmdValid = 1'b0;
  endtask

  task automatic waitResponse();
    for (int i = 0; i < 3000 && !rspValid; i++) @(negedge clk);
    checkOutput("rspValid", 128'(rspValid), 128'd1);
    lastRsp = rspData;
    collectEdges();
    @(negedge clk);
  endtask

  task automatic waitReady();
    for (int i = 0; i < 500 && !cmdReady; i++) @(negedge clk);
    checkOutput("readyAfterReset", 128'(cmdReady), 128'd1);
    collectEdges();
  endtask

  initial begin
    // Reset values and autonomous TAP reset.
    repeat (5) @(negedge clk);
    checkOutput("rstTck", 128'(tck), 128'd0);
    checkOutput("rstTms", 128'(tms), 128'd1);
    checkOutput("rstTdi", 128'(tdi), 128'd0);
    checkOutput("rstReady", 128'(cmdReady), 128'd0);
    checkOutput("rstRspValid", 128'(rspValid), 128'd0);
    checkOutput("rstRspData", 128'(rspData), 128'd0);
    trstN = 1'b1;
    base = totalEdges;
    waitReady();
    checkOutput("resetEdges", 128'(edges), 128'd6);
    checkOutput("resetTms", tmsSeq, 128'h1F);
    checkOutput("idleTck", 128'(tck), 128'd0);
    checkOutput("idleTms", 128'(tms), 128'd0);
    checkOutput("resetNoRsp", 128'(rspSeen), 128'd0);

    // IR scan selecting IDCODE; capture pattern 00101.
    applyStimulus(OpIrScan, 7'd5, 64'h01);
    waitResponse();
    checkOutput("irEdges", 128'(edges), 128'd11);
    checkOutput("irTms", tmsSeq, 128'h303);
    checkOutput("irTdi", tdiSeq, 128'h10);
    checkOutput("irRsp", 128'(lastRsp), 128'h05);

    // DR scan of IDCODE.
    applyStimulus(OpDrScan, 7'd32, 64'h0);
    waitResponse();
    checkOutput("idEdges", 128'(edges), 128'd37);
    checkOutput("idTms", tmsSeq, 128'hC_0000_0001);
    checkOutput("idRsp", 128'(lastRsp), 128'hDEADBEEF);

    // BYPASS: one-bit delay with a leading zero.
    applyStimulus(OpIrScan, 7'd5, 64'h1F);
    waitResponse();
    checkOutput("byIrTdi", tdiSeq, 128'h1F0);
    checkOutput("byIrRsp", 128'(lastRsp), 128'h05);
    applyStimulus(OpDrScan, 7'd8, 64'hA5);
    waitResponse();
    checkOutput("byEdges", 128'(edges), 128'd13);
    checkOutput("byTms", tmsSeq, 128'hC01);
    checkOutput("byTdi", tdiSeq, 128'h528);
    checkOutput("byRsp", 128'(lastRsp), 128'h4A);

    // Length above MaxLen clamps to 64 bits.
    applyStimulus(OpDrScan, 7'd100, 64'h8000_0000_0000_0001);
    waitResponse();
    checkOutput("clampEdges", 128'(edges), 128'd69);
    checkOutput("clampRsp", 128'(lastRsp), 128'h2);

    // TAP_RESET command responds with zero and restores IDCODE.
    applyStimulus(OpTapReset, 7'd0, 64'h0);
    waitResponse();
    checkOutput("tapRstEdges", 128'(edges), 128'd6);
    checkOutput("tapRstTms", tmsSeq, 128'h1F);
    checkOutput("tapRstRsp", 128'(lastRsp), 128'h0);

    // Idle clocking, including zero length treated as one.
    applyStimulus(OpRunIdle, 7'd4, 64'hFFFF);
    waitResponse();
    checkOutput("idleEdges", 128'(edges), 128'd4);
    checkOutput("idleTmsSeq", tmsSeq, 128'h0);
    checkOutput("idleTdiSeq", tdiSeq, 128'h0);
    checkOutput("idleRsp", 128'(lastRsp), 128'h0);
    applyStimulus(OpRunIdle, 7'd0, 64'h0);
    waitResponse();
    checkOutput("idleZeroEdges", 128'(edges), 128'd1);

    // Back-pressure on the response with a command waiting.
    rspReady = 1'b0;
    applyStimulus(OpDrScan, 7'd32, 64'h0);
    waitResponse();
    cmdValid = 1'b1;
    cmdOp    = OpRunIdle;
    cmdLen   = 7'd2;
    cmdData  = '0;
    for (int i = 0; i < 20; i++) begin
      checkOutput("holdValid", 128'(rspValid), 128'd1);
      checkOutput("holdData", 128'(rspData), 128'hDEADBEEF);
      checkOutput("holdReady", 128'(cmdReady), 128'd0);
      @(negedge clk);
    end
    rspReady = 1'b1;
    checkOutput("noAcceptOnConsume", 128'(cmdReady), 128'd0);
    @(negedge clk);
    checkOutput("consumed", 128'(rspValid), 128'd0);
    checkOutput("readyAfterConsume", 128'(cmdReady), 128'd1);
    applyStimulus(OpRunIdle, 7'd2, 64'h0);
    waitResponse();
    checkOutput("queuedEdges", 128'(edges), 128'd2);

    // Reset in the middle of a DR shift.
    applyStimulus(OpDrScan, 7'd32, 64'hFFFF);
    for (int i = 0; i < 400 && (totalEdges - base) < 10; i++) @(negedge clk);
    checkOutput("reachedShift", 128'((totalEdges - base) >= 10), 128'd1);
    trstN = 1'b0;
    rspBefore = rspSeen;
    @(negedge clk);
    checkOutput("midRstTck", 128'(tck), 128'd0);
    checkOutput("midRstTms", 128'(tms), 128'd1);
    checkOutput("midRstTdi", 128'(tdi), 128'd0);
    checkOutput("midRstReady", 128'(cmdReady), 128'd0);
    checkOutput("midRstRspValid", 128'(rspValid), 128'd0);
    checkOutput("midRstRspData", 128'(rspData), 128'd0);
    repeat (4) @(negedge clk);
    trstN = 1'b1;
    base = totalEdges;
    waitReady();
    checkOutput("reResetEdges", 128'(edges), 128'd6);
    checkOutput("reResetTms", tmsSeq, 128'h1F);
    checkOutput("abortNoRsp", 128'(rspSeen), 128'(rspBefore));

    $display("[TB] Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
